// File: rtl/gpio_sampler.sv
// gpio_sampler: synchronise, debounce and track toggles of GPIO pins with capture-and-clear snapshots
module gpio_sampler #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4800,
  parameter int CNT_W           = 13
) (
  input  logic             FX2_CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_raw,
  output logic [WIDTH-1:0] gpio_stable,
  output logic [WIDTH-1:0] gpio_changed,
  output logic             change_event,
  input  logic             snapshot_req,
  output logic             snapshot_valid,
  output logic [WIDTH-1:0] snapshot_level,
  output logic [WIDTH-1:0] snapshot_changed,
  output logic [7:0]       snapshot_count
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       dbc_q, dbc_d;
  logic [WIDTH-1:0] stable_q, stable_d, changed_q, changed_d, toggle;
  logic [WIDTH-1:0] snap_level_q, snap_level_d, snap_changed_q, snap_changed_d;
  logic [7:0]       count_q, count_d, snap_count_q, snap_count_d;
  logic             evt_q, evt_d, snap_valid_q, snap_valid_d, any_t;
  logic [WIDTH-1:0] sync;
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_raw};
    sync     = sync_q[SYNC_STAGES-1];
    stable_d = stable_q;
    toggle   = '0;
    dbc_d    = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sync[b] != stable_q[b]) begin
        if (dbc_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[b] = sync[b];
          toggle[b]   = 1'b1;
        end else begin
          dbc_d[b] = dbc_q[b] + CNT_W'(1);
        end
      end
    end
    any_t          = |toggle;
    evt_d          = any_t;
    // a toggle landing on the request edge seeds the freshly cleared flags and count
    changed_d      = snapshot_req ? toggle : (changed_q | toggle);
    count_d        = snapshot_req ? {7'd0, any_t} :
                     any_t ? ((count_q == 8'hFF) ? count_q : count_q + 8'd1) : count_q;
    snap_valid_d   = snapshot_req;
    snap_level_d   = snapshot_req ? stable_q : snap_level_q;
    snap_changed_d = snapshot_req ? changed_q : snap_changed_q;
    snap_count_d   = snapshot_req ? count_q : snap_count_q;
  end
  always_ff @(posedge FX2_CLK) begin
    if (reset) begin
      sync_q         <= '0;
      dbc_q          <= '0;
      stable_q       <= '0;
      changed_q      <= '0;
      count_q        <= '0;
      evt_q          <= 1'b0;
      snap_valid_q   <= 1'b0;
      snap_level_q   <= '0;
      snap_changed_q <= '0;
      snap_count_q   <= '0;
    end else begin
      sync_q         <= sync_d;
      dbc_q          <= dbc_d;
      stable_q       <= stable_d;
      changed_q      <= changed_d;
      count_q        <= count_d;
      evt_q          <= evt_d;
      snap_valid_q   <= snap_valid_d;
      snap_level_q   <= snap_level_d;
      snap_changed_q <= snap_changed_d;
      snap_count_q   <= snap_count_d;
    end
  end
  assign gpio_stable      = stable_q;
  assign gpio_changed     = changed_q;
  assign change_event     = evt_q;
  assign snapshot_valid   = snap_valid_q;
  assign snapshot_level   = snap_level_q;
  assign snapshot_changed = snap_changed_q;
  assign snapshot_count   = snap_count_q;
endmodule

// File: tb/tb_gpio_sampler.sv
// tb_gpio_sampler: directed vectors with hand-computed expectations for gpio_sampler
module tb_gpio_sampler;
  logic       clk = 1'b0, reset, snapshot_req;
  logic [1:0] gpio_raw, gpio_stable, gpio_changed, snapshot_level, snapshot_changed;
  logic       change_event, snapshot_valid;
  logic [7:0] snapshot_count;
  int         n_vec = 0, n_bad = 0, n_evt;

  gpio_sampler #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .FX2_CLK(clk), .reset(reset), .gpio_raw(gpio_raw), .gpio_stable(gpio_stable),
    .gpio_changed(gpio_changed), .change_event(change_event), .snapshot_req(snapshot_req),
    .snapshot_valid(snapshot_valid), .snapshot_level(snapshot_level),
    .snapshot_changed(snapshot_changed), .snapshot_count(snapshot_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (change_event === 1'b1) n_evt++;
    end
  endtask

  task automatic check_snap(input string tag, input logic [1:0] lvl, input logic [1:0] chg,
                            input logic [7:0] cnt);
    check({tag, "_valid"}, snapshot_valid, 1);
    check({tag, "_level"}, snapshot_level, lvl);
    check({tag, "_changed"}, snapshot_changed, chg);
    check({tag, "_count"}, snapshot_count, cnt);
  endtask

  initial begin
    reset = 1'b1; gpio_raw = 2'b11; snapshot_req = 1'b0; n_evt = 0;
    tick(3);
    check("rst_outputs", {gpio_stable, gpio_changed, change_event, snapshot_valid,
                          snapshot_level, snapshot_changed, snapshot_count}, 0);
    reset = 1'b0;
    tick(9);
    check("rst_stable_e9", gpio_stable, 2'b00);
    tick(1);
    check("rst_stable_e10", gpio_stable, 2'b11);
    check("rst_changed", gpio_changed, 2'b11);
    check("rst_event", change_event, 1);
    tick(1);
    check("rst_event_off", change_event, 0);
    snapshot_req = 1'b1; tick(1); snapshot_req = 1'b0;
    check_snap("rst_snap", 2'b11, 2'b11, 8'd1);
    check("rst_snap_clr", gpio_changed, 2'b00);
    tick(1);
    check("rst_snap_pulse", snapshot_valid, 0);
    check("rst_snap_hold", snapshot_level, 2'b11);

    reset = 1'b1; gpio_raw = 2'b00; tick(1); reset = 1'b0;
    check("rst2_snap_clr", {snapshot_level, snapshot_changed, snapshot_count}, 0);
    gpio_raw = 2'b01;
    tick(9);
    check("bt_stable_e9", gpio_stable, 2'b00);
    tick(1);
    check("bt_stable_e10", gpio_stable, 2'b01);
    check("bt_event", change_event, 1);
    tick(1);
    check("bt_event_off", change_event, 0);
    check("bt_changed", gpio_changed, 2'b01);

    snapshot_req = 1'b1; tick(1);
    check_snap("snap1", 2'b01, 2'b01, 8'd1);
    check("snap1_clr", gpio_changed, 2'b00);
    tick(1); snapshot_req = 1'b0;
    check_snap("snap2", 2'b01, 2'b00, 8'd0);
    tick(1);
    check("snap2_pulse", snapshot_valid, 0);

    n_evt = 0; gpio_raw = 2'b11; tick(7); gpio_raw = 2'b01; tick(15);
    check("gl7_stable", gpio_stable, 2'b01);
    check("gl7_changed", gpio_changed, 2'b00);
    check("gl7_events", n_evt, 0);
    gpio_raw = 2'b11; tick(8); gpio_raw = 2'b01; tick(2);
    check("gl8_stable", gpio_stable, 2'b11);
    check("gl8_event", change_event, 1);
    check("gl8_changed", gpio_changed, 2'b10);
    tick(8);
    check("gl_back_stable", gpio_stable, 2'b01);
    check("gl_back_event", change_event, 1);
    snapshot_req = 1'b1; tick(1); snapshot_req = 1'b0;
    check_snap("gl_snap", 2'b01, 2'b10, 8'd2);

    gpio_raw = 2'b00; tick(10);
    check("sim_pre_stable", gpio_stable, 2'b00);
    check("sim_pre_changed", gpio_changed, 2'b01);
    gpio_raw = 2'b10; tick(9);
    snapshot_req = 1'b1; tick(1);
    check_snap("sim_snap", 2'b00, 2'b01, 8'd1);
    check("sim_changed", gpio_changed, 2'b10);
    check("sim_stable", gpio_stable, 2'b10);
    tick(1); snapshot_req = 1'b0;
    check_snap("sim_next", 2'b10, 2'b10, 8'd1);
    check("sim_next_clr", gpio_changed, 2'b00);

    n_evt = 0;
    for (int k = 0; k < 300; k++) begin
      gpio_raw = ~gpio_raw;
      tick(8);
    end
    tick(2);
    check("sat_events", n_evt, 300);
    check("sat_stable", gpio_stable, 2'b10);
    snapshot_req = 1'b1; tick(1); snapshot_req = 1'b0;
    check_snap("sat_snap", 2'b10, 2'b11, 8'd255);

    reset = 1'b1; tick(1);
    check("final_rst", {gpio_stable, gpio_changed, change_event, snapshot_valid,
                        snapshot_level, snapshot_changed, snapshot_count}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_sampler.md
# gpio_sampler

Conditions the raw GPIO pins before the FX2 USB-2 stage reports them to the host. Each pin is synchronised into the FX2_CLK domain and debounced, and the block keeps sticky per-bit change flags and a saturating toggle count. On a one-cycle request from the USB stage, it atomically captures the debounced level, change flags and count as a snapshot, then clears the flags and count. `gpio_stable` connects directly to the FX2 stage's GPIO input bus.

## Interface
- `WIDTH`, 2: number of GPIO bits.
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, 4800: consecutive agreeing samples required to accept a level (100 µs at 48 MHz), ≥2.
- `CNT_W`, 13: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `FX2_CLK`  in  1: single clock, 48 MHz FX2 interface clock.
- `reset`  in  1: synchronous, active-high reset.
- `gpio_raw`  in  WIDTH: asynchronous pin inputs.
- `gpio_stable`  out  WIDTH: debounced level.
- `gpio_changed`  out  WIDTH: sticky flag per bit, set when that bit's stable level toggles.
- `change_event`  out  1: one-cycle pulse on any toggle of `gpio_stable`.
- `snapshot_req`  in  1: single-cycle capture-and-clear request.
- `snapshot_valid`  out  1: one-cycle pulse, snapshot outputs updated.
- `snapshot_level`  out  WIDTH: captured `gpio_stable`.
- `snapshot_changed`  out  WIDTH: captured `gpio_changed`.
- `snapshot_count`  out  8: captured toggle count.

## Operation
- **Reset.** Synchronous reset clears all state on the next rising edge: synchroniser flops, counters, `gpio_stable`, flags, count and all outputs go to 0. `snapshot_req` is ignored while `reset` is high. Reset mid-debounce discards the partial count.
- **Synchroniser.** Per bit, a `SYNC_STAGES`-flop chain; the last stage is `sync`.
- **Debounce, per bit.**
  - If `sync == stable`: counter <= 0.
  - Else if counter == `DEBOUNCE_CYCLES`-1: `stable` <= `sync`, counter <= 0, `toggle[i]` = 1 for that edge.
  - Else: counter <= counter+1.
- **Toggle bookkeeping.** `toggle` is the vector of bits updating on the current edge, and `any` = OR(`toggle`).
  - `change_event` <= `any`.
  - `gpio_changed` <= `gpio_changed` | `toggle`.
  - `count` <= min(`count`+1, 255) when `any`. The count increments by 1 per toggling cycle, regardless of how many bits toggle.
- **Snapshot** (edge with `snapshot_req`=1):
  - `snapshot_level` <= pre-edge `gpio_stable`.
  - `snapshot_changed` <= pre-edge `gpio_changed`.
  - `snapshot_count` <= pre-edge `count`.
  - `snapshot_valid` <= 1; it is 0 on every edge without a request.
  - `gpio_changed` <= `toggle` and `count` <= (`any` ? 1 : 0). A toggle coinciding with a request is never lost; it appears in the next snapshot.
  - Snapshot outputs hold their value until the next request.
- **Back-to-back requests.** Each request produces its own snapshot. A second consecutive request sees cleared flags and count, except for any same-edge toggles.

## Timing
- Raw level stable before edge 1 appears on `sync` at edge `SYNC_STAGES`, on `gpio_stable` at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`, and on `change_event`/`gpio_changed` at the same edge.
- Pulse acceptance is measured at `sync`:
  - A deviation lasting ≥`DEBOUNCE_CYCLES` clock periods is accepted.
  - A deviation lasting `DEBOUNCE_CYCLES`-1 or fewer periods is rejected with no flag or count change.
- A pin returning to `stable` at any point before acceptance resets its counter to 0.
- `snapshot_req` at edge N gives `snapshot_valid`=1 during cycle N..N+1, with the data valid simultaneously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=8 unless stated.
- **Reset.** Hold `reset` for 3 cycles with `gpio_raw`=2'b11, then release → all outputs 0 during reset. After release, `gpio_stable`=2'b11 exactly 10 edges later and `gpio_changed`=2'b11.
- **Basic toggle.** `gpio_raw[0]` 0→1 before edge 1 → `gpio_stable`=2'b01 and `change_event`=1 at edge 10, `change_event`=0 at edge 11, `gpio_changed`=2'b01.
- **Glitch rejection.** `gpio_raw[1]` high for 7 periods → `gpio_stable`, flags and count unchanged. High for 8 periods → accepted. Returning low after 8 more periods → second toggle, count=2.
- **Snapshot.** After one toggle of bit 0, pulse `snapshot_req` → next cycle `snapshot_valid`=1, `snapshot_level`=2'b01, `snapshot_changed`=2'b01, `snapshot_count`=1. Afterwards `gpio_changed`=0, and a second immediate request yields `snapshot_changed`=0 and `snapshot_count`=0.
- **Simultaneous toggle and request.** Bit 1 toggles on the request edge → snapshot shows the old flags and count; `gpio_changed`=2'b10 and count=1 afterwards; the next snapshot reports `snapshot_changed`=2'b10 and `snapshot_count`=1.
- **Saturation.** 300 accepted toggles without a request → `snapshot_count`=255. Bits toggling together count as 1 per cycle.
